// File: rtl/trig_window_avg_pkg.sv
// Shared types and constants for the triggered window averager.
// State encoding, accumulator width and decimation clamp.
package trig_window_avg_pkg;

  localparam int NOF_LVDS_BITS = 16;
  localparam int CNT_BITS      = 16;
  localparam int MAX_DEC_LOG2  = 4;
  localparam int ACC_W         = NOF_LVDS_BITS + MAX_DEC_LOG2;
  localparam logic [2:0] DEC_CLAMP = 3'(MAX_DEC_LOG2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE
  } state_t;

endpackage

// File: rtl/trig_window_avg_if.sv
// Averaged output bus towards the framework sandbox inputs.
// One strobe per output word, data held between strobes.
interface trig_window_avg_if #(
  parameter int W = 16
);

  logic signed [W-1:0] data_a_o;
  logic signed [W-1:0] data_az_o;
  logic signed [W-1:0] data_b_o;
  logic signed [W-1:0] data_bz_o;
  logic                data_dry_o;

  modport master (
    output data_a_o,
    output data_az_o,
    output data_b_o,
    output data_bz_o,
    output data_dry_o
  );

  modport slave (
    input data_a_o,
    input data_az_o,
    input data_b_o,
    input data_bz_o,
    input data_dry_o
  );

endinterface

// File: rtl/trig_window_avg_lane.sv
// Single-lane block averager: accumulate 2^dec samples, shift, reload.
// The first sample of a group replaces the sum, so groups abut.
module trig_window_avg_lane #(
  parameter int W          = 16,
  parameter int MaxDecLog2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en,
  input  logic                first,
  input  logic                last,
  input  logic [2:0]          dec,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] data
);

  localparam int AccW = W + MaxDecLog2;

  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] ext;
  logic signed [AccW-1:0] sum;
  logic signed [AccW-1:0] avg;

  assign ext = {{MaxDecLog2{sample[W-1]}}, sample};
  assign sum = first ? ext : acc + ext;
  // Arithmetic shift gives floor of the mean.
  assign avg = sum >>> dec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc  <= '0;
      data <= '0;
    end else if (en) begin
      acc <= sum;
      if (last) data <= avg[W-1:0];
    end
  end

endmodule

// File: rtl/trig_window_avg.sv
// Triggered, delayed, block-averaging capture stage for four lanes.
// Arm, wait for trigger edge plus delay, emit length averaged words.
module trig_window_avg
  import trig_window_avg_pkg::*;
#(
  parameter int NofLvdsBits = NOF_LVDS_BITS,
  parameter int CntBits     = CNT_BITS,
  parameter int MaxDecLog2  = MAX_DEC_LOG2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic signed [NofLvdsBits-1:0] ac_data_a_i,
  input  logic signed [NofLvdsBits-1:0] ac_data_az_i,
  input  logic signed [NofLvdsBits-1:0] ac_data_b_i,
  input  logic signed [NofLvdsBits-1:0] ac_data_bz_i,
  input  logic                          trigger_i,
  input  logic                          arm_i,
  input  logic                          abort_i,
  input  logic [CntBits-1:0]            delay_i,
  input  logic [CntBits-1:0]            length_i,
  input  logic [2:0]                    dec_log2_i,
  trig_window_avg_if.master             out_if,
  output logic                          armed_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          trig_missed_o
);

  localparam logic [2:0] DecMax = 3'(MaxDecLog2);

  state_t                  state;
  logic                    trig_q;
  logic [CntBits-1:0]      dly;
  logic [CntBits-1:0]      len;
  logic [CntBits-1:0]      dcnt;
  logic [CntBits-1:0]      wcnt;
  logic [2:0]              dec;
  logic [2:0]              dec_in;
  logic [MaxDecLog2-1:0]   gcnt;
  logic [MaxDecLog2-1:0]   gmax;
  logic                    edge_e;
  logic                    cap;
  logic                    first;
  logic                    last;
  logic                    fin;
  logic                    dry_q;

  assign edge_e  = trigger_i & ~trig_q;
  assign dec_in  = (dec_log2_i > DecMax) ? DecMax : dec_log2_i;
  assign gmax    = ~({MaxDecLog2{1'b1}} << dec);
  // Abort suppresses the lane update so held outputs stay intact.
  assign cap     = (state == S_CAPTURE) && !abort_i;
  assign first   = (gcnt == '0);
  assign last    = (gcnt == gmax);
  assign fin     = last && (wcnt == len - 1'b1);
  assign armed_o = (state == S_ARMED);
  assign busy_o  = (state == S_DELAY) || (state == S_CAPTURE);

  assign out_if.data_dry_o = dry_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      trig_q        <= 1'b0;
      dly           <= '0;
      len           <= '0;
      dcnt          <= '0;
      wcnt          <= '0;
      dec           <= '0;
      gcnt          <= '0;
      dry_q         <= 1'b0;
      done_o        <= 1'b0;
      trig_missed_o <= 1'b0;
    end else begin
      trig_q <= trigger_i;
      dry_q  <= 1'b0;
      done_o <= 1'b0;
      if (edge_e && busy_o) trig_missed_o <= 1'b1;
      if (abort_i) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arm_i) begin
              dly           <= delay_i;
              len           <= length_i;
              dec           <= dec_in;
              trig_missed_o <= 1'b0;
              if (length_i == '0) done_o <= 1'b1;
              else                state  <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (edge_e) begin
              dcnt  <= '0;
              gcnt  <= '0;
              wcnt  <= '0;
              state <= (dly == '0) ? S_CAPTURE : S_DELAY;
            end
          end
          S_DELAY: begin
            if (dcnt == dly - 1'b1) state <= S_CAPTURE;
            else                    dcnt  <= dcnt + 1'b1;
          end
          S_CAPTURE: begin
            gcnt <= last ? '0 : gcnt + 1'b1;
            if (last) begin
              dry_q <= 1'b1;
              wcnt  <= wcnt + 1'b1;
            end
            if (fin) begin
              done_o <= 1'b1;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic signed [NofLvdsBits-1:0] lane_a;
  logic signed [NofLvdsBits-1:0] lane_az;
  logic signed [NofLvdsBits-1:0] lane_b;
  logic signed [NofLvdsBits-1:0] lane_bz;

  trig_window_avg_lane #(
    .W(NofLvdsBits), .MaxDecLog2(MaxDecLog2)
  ) u_lane_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(cap),
    .first(first), .last(last), .dec(dec),
    .sample(ac_data_a_i), .data(lane_a)
  );

  trig_window_avg_lane #(
    .W(NofLvdsBits), .MaxDecLog2(MaxDecLog2)
  ) u_lane_az (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(cap),
    .first(first), .last(last), .dec(dec),
    .sample(ac_data_az_i), .data(lane_az)
  );

  trig_window_avg_lane #(
    .W(NofLvdsBits), .MaxDecLog2(MaxDecLog2)
  ) u_lane_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(cap),
    .first(first), .last(last), .dec(dec),
    .sample(ac_data_b_i), .data(lane_b)
  );

  trig_window_avg_lane #(
    .W(NofLvdsBits), .MaxDecLog2(MaxDecLog2)
  ) u_lane_bz (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(cap),
    .first(first), .last(last), .dec(dec),
    .sample(ac_data_bz_i), .data(lane_bz)
  );

  assign out_if.data_a_o  = lane_a;
  assign out_if.data_az_o = lane_az;
  assign out_if.data_b_o  = lane_b;
  assign out_if.data_bz_o = lane_bz;

endmodule

// File: tb/tb_trig_window_avg.sv
// Directed bench for trig_window_avg with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_trig_window_avg;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] a, az, b, bz;
  logic               trig;
  logic               arm;
  logic               abrt;
  logic [15:0]        dly;
  logic [15:0]        len;
  logic [2:0]         dec;
  logic               armed, busy, done, missed;

  int checks   = 0;
  int failures = 0;

  trig_window_avg_if #(.W(16)) out_if ();

  trig_window_avg dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ac_data_a_i(a), .ac_data_az_i(az),
    .ac_data_b_i(b), .ac_data_bz_i(bz),
    .trigger_i(trig), .arm_i(arm), .abort_i(abrt),
    .delay_i(dly), .length_i(len), .dec_log2_i(dec),
    .out_if(out_if),
    .armed_o(armed), .busy_o(busy),
    .done_o(done), .trig_missed_o(missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [15:0] d,
                        input logic [15:0] l,
                        input logic [2:0]  dc);
    dly = d; len = l; dec = dc;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic set_all(input logic signed [15:0] v);
    a = v; az = v; b = v; bz = v;
  endtask

  initial begin
    rst_n = 1'b0;
    set_all(16'sd0);
    trig = 0; arm = 0; abrt = 0;
    dly = 0; len = 0; dec = 0;
    step(); step();
    chk("rst_dry", 16'(out_if.data_dry_o), 16'd0);
    chk("rst_a", out_if.data_a_o, 16'd0);
    chk("rst_armed", 16'(armed), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    rst_n = 1'b1;
    step();

    // Ramp, delay 3, length 2, dec 0, edge at cycle 10
    do_arm(16'd3, 16'd2, 3'd0);
    chk("t1_armed", 16'(armed), 16'd1);
    for (int i = 0; i <= 20; i++) begin
      a = 16'(i);
      trig = (i == 10 || i == 11);
      step();
      chk("t1_dry", 16'(out_if.data_dry_o),
          16'(i == 14 || i == 15));
      chk("t1_done", 16'(done), 16'(i == 15));
      if (i == 12) chk("t1_busy", 16'(busy), 16'd1);
      if (i == 14) chk("t1_a0", out_if.data_a_o, 16'd14);
      if (i == 15) chk("t1_a1", out_if.data_a_o, 16'd15);
    end
    chk("t1_idle", 16'(busy), 16'd0);
    chk("t1_hold", out_if.data_a_o, 16'd15);
    trig = 0;

    // dec 1, pairs (3,4) and (-3,-4), delay 0
    do_arm(16'd0, 16'd2, 3'd1);
    for (int i = 0; i <= 7; i++) begin
      trig = (i == 1);
      a = (i % 2 == 0) ? 16'sd3 : 16'sd4;
      b = -a;
      step();
      chk("t2_dry", 16'(out_if.data_dry_o),
          16'(i == 3 || i == 5));
      if (i == 3 || i == 5) begin
        chk("t2_a", out_if.data_a_o, 16'd3);
        chk("t2_b", out_if.data_b_o, 16'hFFFC);
      end
      chk("t2_done", 16'(done), 16'(i == 5));
    end
    trig = 0;

    // dec 4 at full-scale positive then negative
    do_arm(16'd0, 16'd2, 3'd4);
    for (int i = 0; i <= 36; i++) begin
      trig = (i == 1);
      set_all(i <= 17 ? 16'sh7FFF : 16'sh8000);
      step();
      chk("t3_dry", 16'(out_if.data_dry_o),
          16'(i == 17 || i == 33));
      if (i == 17) begin
        chk("t3_a_p", out_if.data_a_o, 16'h7FFF);
        chk("t3_az_p", out_if.data_az_o, 16'h7FFF);
        chk("t3_b_p", out_if.data_b_o, 16'h7FFF);
        chk("t3_bz_p", out_if.data_bz_o, 16'h7FFF);
      end
      if (i == 33) begin
        chk("t3_a_n", out_if.data_a_o, 16'h8000);
        chk("t3_az_n", out_if.data_az_o, 16'h8000);
        chk("t3_b_n", out_if.data_b_o, 16'h8000);
        chk("t3_bz_n", out_if.data_bz_o, 16'h8000);
        chk("t3_done", 16'(done), 16'd1);
      end
    end
    trig = 0;

    // dec 7 clamps to 4: ramp 2..17 sums to 152, floor(152/16)=9
    do_arm(16'd0, 16'd1, 3'd7);
    for (int i = 0; i <= 19; i++) begin
      trig = (i == 1);
      a = 16'(i);
      step();
      chk("t4_dry", 16'(out_if.data_dry_o), 16'(i == 17));
      if (i == 17) chk("t4_a", out_if.data_a_o, 16'd9);
    end
    trig = 0;

    // Second edge during capture sets trig_missed only
    do_arm(16'd0, 16'd4, 3'd0);
    for (int i = 0; i <= 7; i++) begin
      trig = (i == 1 || i == 3 || i == 4);
      a = 16'(2 * i + 1);
      step();
      chk("t5_dry", 16'(out_if.data_dry_o),
          16'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5)
        chk("t5_a", out_if.data_a_o, 16'(2 * i + 1));
      chk("t5_done", 16'(done), 16'(i == 5));
    end
    chk("t5_missed", 16'(missed), 16'd1);
    trig = 0;
    step();

    // Re-arm clears trig_missed; abort mid-group
    do_arm(16'd0, 16'd5, 3'd2);
    chk("t6_clr", 16'(missed), 16'd0);
    chk("t6_armed", 16'(armed), 16'd1);
    for (int i = 0; i <= 9; i++) begin
      trig = (i == 1);
      abrt = (i == 3);
      a = 16'sd100;
      step();
      if (i == 2) chk("t6_busy", 16'(busy), 16'd1);
      if (i == 3) begin
        chk("t6_ab_armed", 16'(armed), 16'd0);
        chk("t6_ab_busy", 16'(busy), 16'd0);
      end
      chk("t6_dry", 16'(out_if.data_dry_o), 16'd0);
      chk("t6_done", 16'(done), 16'd0);
    end
    abrt = 0;
    trig = 0;

    // Zero length: done at once, no strobe
    do_arm(16'd0, 16'd0, 3'd0);
    chk("t7_done", 16'(done), 16'd1);
    chk("t7_dry", 16'(out_if.data_dry_o), 16'd0);
    chk("t7_armed", 16'(armed), 16'd0);
    step();
    chk("t7_done2", 16'(done), 16'd0);

    // Asynchronous reset mid-shot
    do_arm(16'd0, 16'd3, 3'd0);
    for (int i = 0; i <= 2; i++) begin
      trig = (i == 1);
      a = 16'sh0055;
      step();
    end
    chk("t8_dry", 16'(out_if.data_dry_o), 16'd1);
    chk("t8_a", out_if.data_a_o, 16'h0055);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_dry", 16'(out_if.data_dry_o), 16'd0);
    chk("t8_rst_a", out_if.data_a_o, 16'd0);
    chk("t8_rst_busy", 16'(busy), 16'd0);
    #3;
    rst_n = 1'b1;
    trig = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t8_post_dry", 16'(out_if.data_dry_o), 16'd0);
      chk("t8_post_busy", 16'(busy), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
